instr_loader: RTL and testbench

Byte-stream instruction loader that writes program images into instruction memory through the fetch stage's debug write port (`dbg_wr_en`/`dbg_addr`/`dbg_instr`). It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and issues one write per word at consecutive word addresses. It sits between a host byte source (UART receiver or testbench) and the fetch stage. It holds the CPU while loading.

---
 rtl/instr_loader.sv | 160 ++++++++++++++++
 tb/tb_instr_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: turns a length-prefixed little-endian byte stream into
// 32-bit instruction-memory writes through the fetch stage debug port.
// The CPU is held for the whole load.
//
// Handshake: a byte moves when in_valid && in_ready on a rising edge.
// in_valid may drop at any time (assembly just stalls); in_ready depends
// only on the state register, so it never waits on in_valid.
module instr_loader #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    output logic            busy,
    output logic            cpu_hold,
    output logic            done,
    output logic            error,
    output logic [2:0]      state_o
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS + 1);
    localparam logic [31:0] DEPTH_N = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t            state_q;
    logic [1:0]        byte_cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [31:0]       n_q;
    logic [31:0]       n_d;
    logic [XLEN-1:0]   word_q;
    logic [XLEN-1:0]   word_d;
    logic [XLEN-1:0]   addr_d;
    logic              dbg_wr_en_q;
    logic [XLEN-1:0]   dbg_addr_q;
    logic [XLEN-1:0]   dbg_instr_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              accept;

    assign accept   = in_valid && in_ready;
    assign in_ready = (state_q == HEADER) || (state_q == DATA);
    assign cpu_hold = (state_q == HEADER) || (state_q == DATA) || (state_q == WRITE);

    assign dbg_wr_en = dbg_wr_en_q;
    assign dbg_addr  = dbg_addr_q;
    assign dbg_instr = dbg_instr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign state_o   = state_q;

    assign idx_d  = idx_q + IDX_W'(1);
    assign addr_d = BASE_ADDR + (XLEN'(idx_q) << 2);

    // Drop the incoming byte into its little-endian lane of the count / word.
    always_comb begin
        n_d    = n_q;
        word_d = word_q;
        n_d[{byte_cnt_q, 3'b000} +: 8]    = in_data;
        word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
    end

    // Load sequencer with registered write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            idx_q       <= '0;
            n_q         <= '0;
            word_q      <= '0;
            dbg_wr_en_q <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_instr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // The write port is a one-cycle pulse; address/data read 0 otherwise.
            dbg_wr_en_q <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_instr_q <= '0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q    <= HEADER;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        byte_cnt_q <= '0;
                        idx_q      <= '0;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        n_q        <= n_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (n_d == 32'd0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else if (n_d > DEPTH_N) begin
                                state_q <= ERR;
                                error_q <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q     <= WRITE;
                            dbg_wr_en_q <= 1'b1;
                            dbg_addr_q  <= addr_d;
                            dbg_instr_q <= word_d;
                        end
                    end
                end
                WRITE: begin
                    idx_q <= idx_d;
                    if (32'(idx_d) == n_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DATA;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: two instances (base 0 and base 0x100) share one
// byte stream; a scoreboard of expected (address, word) pairs per instance
// is filled from the image before it is sent.
module tb_instr_loader;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE0 = 32'h0;
    localparam logic [31:0] BASE1 = 32'h100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    always #5 clk = ~clk;

    logic        in_ready0, wr_en0, busy0, cpu_hold0, done0, error0;
    logic [31:0] addr0, instr0;
    logic [2:0]  state0;
    logic        in_ready1, wr_en1, busy1, cpu_hold1, done1, error1;
    logic [31:0] addr1, instr1;
    logic [2:0]  state1;

    instr_loader #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .dbg_wr_en(wr_en0), .dbg_addr(addr0), .dbg_instr(instr0),
        .busy(busy0), .cpu_hold(cpu_hold0), .done(done0), .error(error0), .state_o(state0)
    );

    instr_loader #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .dbg_wr_en(wr_en1), .dbg_addr(addr1), .dbg_instr(instr1),
        .busy(busy1), .cpu_hold(cpu_hold1), .done(done1), .error(error1), .state_o(state1)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    logic [31:0] img_q[$];
    int          wr_cnt0 = 0;
    int          wr_cnt1 = 0;
    logic        prev_wr0 = 1'b0;
    logic        prev_wr1 = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en0) begin
                wr_cnt0++;
                check_val("wr0_ready_low", 64'(in_ready0), 64'd0);
                check_val("wr0_not_back_to_back", 64'(prev_wr0), 64'd0);
                if (exp_q0.size() == 0) check_val("wr0_expected_pending", 64'(exp_q0.size()), 64'd1);
                else check_val("wr0_addr_instr", {addr0, instr0}, exp_q0.pop_front());
            end else begin
                check_val("wr0_bus_zero_when_idle", {addr0, instr0}, 64'd0);
            end
            if (wr_en1) begin
                wr_cnt1++;
                if (exp_q1.size() == 0) check_val("wr1_expected_pending", 64'(exp_q1.size()), 64'd1);
                else check_val("wr1_addr_instr", {addr1, instr1}, exp_q1.pop_front());
            end
        end
        prev_wr0 = wr_en0;
        prev_wr1 = wr_en1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int gap_for(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int mode);
        int budget;
        int gap;
        gap = gap_for(mode);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        while (!in_ready0 && budget < 100) begin
            tick();
            budget++;
        end
        if (!in_ready0) begin
            check_val("ready_timeout", 64'(in_ready0), 64'd1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Sends a 32-bit value as four little-endian bytes; optionally pulses
    // start in the middle of the word.
    task automatic send_word32(input logic [31:0] w, input int mode, input bit poke);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8], mode);
            if (poke && b == 1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_status0", 64'({busy0, cpu_hold0, in_ready0, done0, error0}), 64'(5'b11100));
        check_val("start_status1", 64'({busy1, cpu_hold1, in_ready1, done1, error1}), 64'(5'b11100));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_bus0"}, {addr0, instr0}, 64'd0);
        check_val({tag, "_flags0"}, 64'({in_ready0, wr_en0, busy0, cpu_hold0, done0, error0}), 64'd0);
        check_val({tag, "_flags1"}, 64'({in_ready1, wr_en1, busy1, cpu_hold1, done1, error1}), 64'd0);
    endtask

    // Full load of img_q announced with count n; poke_word < 0 means no start pulse.
    task automatic load(input logic [31:0] n, input int mode, input int poke_word);
        int n_exp;
        wr_cnt0 = 0;
        wr_cnt1 = 0;
        do_start();
        send_word32(n, mode, 1'b0);
        if (n == 32'd0 || n > 32'(DEPTH)) begin
            n_exp = 0;
            check_val("header_outcome0", 64'({done0, error0, busy0}),
                      (n == 32'd0) ? 64'(3'b100) : 64'(3'b010));
            check_val("header_outcome1", 64'({done1, error1, busy1}),
                      (n == 32'd0) ? 64'(3'b100) : 64'(3'b010));
            repeat (3) tick();
        end else begin
            n_exp = int'(n);
            for (int i = 0; i < n_exp; i++) begin
                exp_q0.push_back({BASE0 + 32'(4 * i), img_q[i]});
                exp_q1.push_back({BASE1 + 32'(4 * i), img_q[i]});
            end
            for (int i = 0; i < n_exp; i++) begin
                send_word32(img_q[i], mode, (i == poke_word));
                check_val("write_latency", 64'({wr_en0, in_ready0, done0}), 64'(3'b100));
            end
            tick();
            check_val("done_after_last_write", 64'({done0, busy0, wr_en0, done1, error0}),
                      64'(5'b10010));
        end
        check_val("pending_writes0", 64'(exp_q0.size()), 64'd0);
        check_val("pending_writes1", 64'(exp_q1.size()), 64'd0);
        check_val("write_count0", 64'(wr_cnt0), 64'(n_exp));
        check_val("write_count1", 64'(wr_cnt1), 64'(n_exp));
    endtask

    task automatic random_image(input int n);
        img_q.delete();
        for (int i = 0; i < n; i++) img_q.push_back($urandom);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        check_outputs_zero("idle_after_reset");

        // Basic image, valid held high, then with valid toggling.
        img_q.delete();
        img_q.push_back(32'h0000_0013);
        img_q.push_back(32'h0010_0093);
        load(32'd2, 0, -1);
        load(32'd2, 1, -1);

        // Header boundaries.
        img_q.delete();
        load(32'd0, 0, -1);
        load(32'(DEPTH + 1), 0, -1);
        load(32'h1000_0002, 1, -1);

        // Start pulsed mid-word is ignored.
        random_image(3);
        load(32'd3, 0, 1);

        // Randomized images with random gaps.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, 6));
            random_image(n);
            load(32'(n), 2, -1);
        end

        // Reset in the middle of a word: first word written, second discarded.
        random_image(3);
        exp_q0.delete();
        exp_q1.delete();
        exp_q0.push_back({BASE0, img_q[0]});
        exp_q1.push_back({BASE1, img_q[0]});
        do_start();
        send_word32(32'd3, 0, 1'b0);
        send_word32(img_q[0], 0, 1'b0);
        send_byte(img_q[1][7:0], 0);
        send_byte(img_q[1][15:8], 0);
        check_val("pre_reset_writes", 64'(exp_q0.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q0.delete();
        exp_q1.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check_outputs_zero("after_mid_reset");
        random_image(2);
        load(32'd2, 0, -1);

        // Full-depth image: last address is 4*(DEPTH-1).
        random_image(DEPTH);
        load(32'(DEPTH), 0, -1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
